// File: rtl/fwd_sel_ctrl.sv
// EX-stage operand forwarding select and load-use stall generator.
// Keeps a shadow copy of the destination info for the EX, MEM and WB stages.
module fwd_sel_ctrl #(
    parameter int unsigned REG_W    = 5,
    parameter int unsigned ZERO_REG = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             id_valid_i,
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    input  logic [REG_W-1:0] id_rd_i,
    input  logic             id_reg_write_i,
    input  logic             id_mem_read_i,
    input  logic             flush_i,
    output logic [1:0]       sel_a_o,
    output logic [1:0]       sel_b_o,
    output logic             stall_o,
    output logic             ex_mem_read_o
);

    localparam logic [REG_W-1:0] ZERO_R = REG_W'(ZERO_REG);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_WB  = 2'b10;

    logic             ex_v_q,  ex_v_d;
    logic [REG_W-1:0] ex_rs_q, ex_rs_d;
    logic [REG_W-1:0] ex_rt_q, ex_rt_d;
    logic [REG_W-1:0] ex_rd_q, ex_rd_d;
    logic             ex_we_q, ex_we_d;
    logic             ex_mr_q, ex_mr_d;

    logic             mem_v_q;
    logic [REG_W-1:0] mem_rd_q;
    logic             mem_we_q;
    logic             mem_mr_q;

    logic             wb_v_q;
    logic [REG_W-1:0] wb_rd_q;
    logic             wb_we_q;

    logic ex_live, mem_live, wb_live;

    // Downstream stages always advance; EX takes ID or a bubble.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ex_v_q   <= 1'b0;
            ex_rs_q  <= '0;
            ex_rt_q  <= '0;
            ex_rd_q  <= '0;
            ex_we_q  <= 1'b0;
            ex_mr_q  <= 1'b0;
            mem_v_q  <= 1'b0;
            mem_rd_q <= '0;
            mem_we_q <= 1'b0;
            mem_mr_q <= 1'b0;
            wb_v_q   <= 1'b0;
            wb_rd_q  <= '0;
            wb_we_q  <= 1'b0;
        end else begin
            ex_v_q   <= ex_v_d;
            ex_rs_q  <= ex_rs_d;
            ex_rt_q  <= ex_rt_d;
            ex_rd_q  <= ex_rd_d;
            ex_we_q  <= ex_we_d;
            ex_mr_q  <= ex_mr_d;
            mem_v_q  <= ex_v_q;
            mem_rd_q <= ex_rd_q;
            mem_we_q <= ex_we_q;
            mem_mr_q <= ex_mr_q;
            wb_v_q   <= mem_v_q;
            wb_rd_q  <= mem_rd_q;
            wb_we_q  <= mem_we_q;
        end
    end

    always_comb begin
        ex_live  = ex_v_q  && ex_we_q  && (ex_rd_q  != ZERO_R);
        mem_live = mem_v_q && mem_we_q && (mem_rd_q != ZERO_R);
        wb_live  = wb_v_q  && wb_we_q  && (wb_rd_q  != ZERO_R);
    end

    // Select codes depend only on registered stage state; MEM (younger) wins over WB.
    always_comb begin
        sel_a_o = SEL_RF;
        sel_b_o = SEL_RF;
        if (ex_v_q) begin
            if (mem_live && (mem_rd_q == ex_rs_q)) begin
                sel_a_o = SEL_MEM;
            end else if (wb_live && (wb_rd_q == ex_rs_q)) begin
                sel_a_o = SEL_WB;
            end
            if (mem_live && (mem_rd_q == ex_rt_q)) begin
                sel_b_o = SEL_MEM;
            end else if (wb_live && (wb_rd_q == ex_rt_q)) begin
                sel_b_o = SEL_WB;
            end
        end
    end

    always_comb begin
        stall_o       = id_valid_i && !flush_i && ex_live && ex_mr_q &&
                        ((ex_rd_q == id_rs_i) || (ex_rd_q == id_rt_i));
        ex_mem_read_o = ex_v_q && ex_mr_q;
    end

    // Stall or flush turns the EX slot into an all-zero bubble.
    always_comb begin
        ex_v_d  = 1'b0;
        ex_rs_d = '0;
        ex_rt_d = '0;
        ex_rd_d = '0;
        ex_we_d = 1'b0;
        ex_mr_d = 1'b0;
        if (!stall_o && !flush_i) begin
            ex_v_d  = id_valid_i;
            ex_rs_d = id_rs_i;
            ex_rt_d = id_rt_i;
            ex_rd_d = id_rd_i;
            ex_we_d = id_reg_write_i;
            ex_mr_d = id_mem_read_i;
        end
    end

    // A load sitting in MEM must never be forwarded; the stall guarantees a gap.
    a_no_mem_load_fwd: assert property (@(posedge clk_i) disable iff (rst_i)
        !(((sel_a_o == SEL_MEM) || (sel_b_o == SEL_MEM)) && mem_mr_q));

endmodule

// File: tb/tb_fwd_sel_ctrl.sv
// Self-checking bench for fwd_sel_ctrl: directed hazard scenarios plus a
// randomized run compared against an instruction-level pipeline model.
module tb_fwd_sel_ctrl;

    typedef struct {
        bit       v;
        bit [4:0] rs;
        bit [4:0] rt;
        bit [4:0] rd;
        bit       we;
        bit       mr;
    } instr_t;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       id_valid_i = 1'b0;
    logic [4:0] id_rs_i = '0;
    logic [4:0] id_rt_i = '0;
    logic [4:0] id_rd_i = '0;
    logic       id_reg_write_i = 1'b0;
    logic       id_mem_read_i = 1'b0;
    logic       flush_i = 1'b0;
    logic [1:0] sel_a_o;
    logic [1:0] sel_b_o;
    logic       stall_o;
    logic       ex_mem_read_o;

    int n_vec = 0;
    int n_err = 0;

    // pipe[0] = instruction in EX, pipe[1] = MEM, pipe[2] = WB
    instr_t pipe[3];
    instr_t cur_id;
    bit     cur_flush;
    bit [1:0] exp_a, exp_b;
    bit       exp_stall, exp_emr;

    fwd_sel_ctrl dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .id_valid_i     (id_valid_i),
        .id_rs_i        (id_rs_i),
        .id_rt_i        (id_rt_i),
        .id_rd_i        (id_rd_i),
        .id_reg_write_i (id_reg_write_i),
        .id_mem_read_i  (id_mem_read_i),
        .flush_i        (flush_i),
        .sel_a_o        (sel_a_o),
        .sel_b_o        (sel_b_o),
        .stall_o        (stall_o),
        .ex_mem_read_o  (ex_mem_read_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic instr_t mk(bit v, bit [4:0] rs, bit [4:0] rt, bit [4:0] rd, bit we, bit mr);
        instr_t i;
        i.v = v; i.rs = rs; i.rt = rt; i.rd = rd; i.we = we; i.mr = mr;
        return i;
    endfunction

    function automatic instr_t nop();
        return mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    endfunction

    function automatic bit writes(instr_t i, bit [4:0] r);
        return i.v && i.we && (i.rd != 5'd0) && (i.rd == r);
    endfunction

    // Youngest older producer of src: one ahead -> 01, two ahead -> 10, else regfile.
    function automatic bit [1:0] ref_sel(bit [4:0] src);
        if (!pipe[0].v) return 2'b00;
        for (int age = 1; age <= 2; age++) begin
            if (writes(pipe[age], src)) return (age == 1) ? 2'b01 : 2'b10;
        end
        return 2'b00;
    endfunction

    function automatic void clear_model();
        for (int k = 0; k < 3; k++) pipe[k] = nop();
    endfunction

    // Drive ID fields just after the falling edge and compute expected outputs.
    task automatic apply(instr_t id, bit fl);
        @(negedge clk_i);
        cur_id = id; cur_flush = fl;
        id_valid_i = id.v; id_rs_i = id.rs; id_rt_i = id.rt; id_rd_i = id.rd;
        id_reg_write_i = id.we; id_mem_read_i = id.mr; flush_i = fl;
        exp_a = ref_sel(pipe[0].rs);
        exp_b = ref_sel(pipe[0].rt);
        exp_emr = pipe[0].v && pipe[0].mr;
        exp_stall = id.v && !fl && pipe[0].mr &&
                    (writes(pipe[0], id.rs) || writes(pipe[0], id.rt));
        #1;
    endtask

    task automatic advance();
        @(posedge clk_i);
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = (exp_stall || cur_flush) ? nop() : cur_id;
    endtask

    task automatic step(instr_t id, bit fl);
        apply(id, fl);
        advance();
    endtask

    task automatic drain();
        for (int k = 0; k < 3; k++) step(nop(), 1'b0);
    endtask

    task automatic test_reset();
        clear_model();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        n_vec++;
        if ({sel_a_o, sel_b_o, stall_o, ex_mem_read_o} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b want 000000", {sel_a_o, sel_b_o, stall_o, ex_mem_read_o});
        end
        rst_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        drain();
        step(mk(1, 5'd1, 5'd2, 5'd3, 1, 0), 0);
        step(mk(1, 5'd3, 5'd4, 5'd5, 1, 0), 0);
        apply(nop(), 0);
        n_vec++;
        if (sel_a_o !== 2'b01 || sel_b_o !== 2'b00) begin
            n_err++;
            $display("FAIL b2b_mem_fwd: got a=%b b=%b want a=01 b=00", sel_a_o, sel_b_o);
        end
        advance();
        drain();
        step(mk(1, 5'd1, 5'd2, 5'd3, 1, 0), 0);
        step(nop(), 0);
        step(mk(1, 5'd3, 5'd4, 5'd5, 1, 0), 0);
        apply(nop(), 0);
        n_vec++;
        if (sel_a_o !== 2'b10 || sel_b_o !== 2'b00) begin
            n_err++;
            $display("FAIL gap1_wb_fwd: got a=%b b=%b want a=10 b=00", sel_a_o, sel_b_o);
        end
        advance();
        step(nop(), 0);
        apply(nop(), 0);
        n_vec++;
        if (sel_a_o !== 2'b00) begin
            n_err++;
            $display("FAIL bubble_sel: got a=%b want 00", sel_a_o);
        end
        advance();
    endtask

    task automatic test_mem_beats_wb();
        drain();
        step(mk(1, 5'd1, 5'd2, 5'd3, 1, 0), 0);
        step(mk(1, 5'd1, 5'd4, 5'd3, 1, 0), 0);
        step(mk(1, 5'd3, 5'd3, 5'd6, 1, 0), 0);
        apply(nop(), 0);
        n_vec++;
        if (sel_a_o !== 2'b01 || sel_b_o !== 2'b01) begin
            n_err++;
            $display("FAIL mem_beats_wb: got a=%b b=%b want 01 01", sel_a_o, sel_b_o);
        end
        advance();
        drain();
        step(mk(1, 5'd1, 5'd2, 5'd8, 1, 0), 0);
        step(mk(1, 5'd1, 5'd2, 5'd9, 1, 0), 0);
        step(mk(1, 5'd8, 5'd9, 5'd10, 1, 0), 0);
        apply(nop(), 0);
        n_vec++;
        if (sel_a_o !== 2'b10 || sel_b_o !== 2'b01) begin
            n_err++;
            $display("FAIL split_stage_fwd: got a=%b b=%b want 10 01", sel_a_o, sel_b_o);
        end
        advance();
    endtask

    task automatic test_load_use();
        instr_t lw, use_i;
        lw    = mk(1, 5'd1, 5'd2, 5'd2, 1, 1);
        use_i = mk(1, 5'd2, 5'd1, 5'd7, 1, 0);
        drain();
        step(lw, 0);
        apply(use_i, 0);
        n_vec++;
        if (stall_o !== 1'b1 || ex_mem_read_o !== 1'b1) begin
            n_err++;
            $display("FAIL load_use_stall: got stall=%b emr=%b want 1 1", stall_o, ex_mem_read_o);
        end
        advance();
        apply(use_i, 0);
        n_vec++;
        if (stall_o !== 1'b0 || sel_a_o !== 2'b00 || sel_b_o !== 2'b00) begin
            n_err++;
            $display("FAIL stall_one_cycle: got stall=%b a=%b b=%b want 0 00 00", stall_o, sel_a_o, sel_b_o);
        end
        advance();
        apply(nop(), 0);
        n_vec++;
        if (sel_a_o !== 2'b10 || sel_b_o !== 2'b00 || ex_mem_read_o !== 1'b0) begin
            n_err++;
            $display("FAIL load_wb_fwd: got a=%b b=%b emr=%b want 10 00 0", sel_a_o, sel_b_o, ex_mem_read_o);
        end
        advance();
    endtask

    task automatic test_zero_reg();
        drain();
        step(mk(1, 5'd1, 5'd2, 5'd0, 1, 0), 0);
        step(mk(1, 5'd0, 5'd0, 5'd4, 1, 0), 0);
        apply(nop(), 0);
        n_vec++;
        if (sel_a_o !== 2'b00 || sel_b_o !== 2'b00) begin
            n_err++;
            $display("FAIL r0_no_fwd: got a=%b b=%b want 00 00", sel_a_o, sel_b_o);
        end
        advance();
        drain();
        step(mk(1, 5'd1, 5'd0, 5'd0, 1, 1), 0);
        apply(mk(1, 5'd0, 5'd3, 5'd4, 1, 0), 0);
        n_vec++;
        if (stall_o !== 1'b0) begin
            n_err++;
            $display("FAIL r0_no_stall: got stall=%b want 0", stall_o);
        end
        advance();
    endtask

    task automatic test_flush();
        drain();
        step(mk(1, 5'd1, 5'd2, 5'd3, 1, 0), 0);
        step(nop(), 0);
        step(mk(1, 5'd3, 5'd3, 5'd5, 1, 0), 1);
        apply(nop(), 0);
        n_vec++;
        if (sel_a_o !== 2'b00 || sel_b_o !== 2'b00) begin
            n_err++;
            $display("FAIL flush_bubble: got a=%b b=%b want 00 00", sel_a_o, sel_b_o);
        end
        advance();
        drain();
        step(mk(1, 5'd1, 5'd2, 5'd2, 1, 1), 0);
        apply(mk(1, 5'd2, 5'd2, 5'd7, 1, 0), 1);
        n_vec++;
        if (stall_o !== 1'b0) begin
            n_err++;
            $display("FAIL flush_masks_stall: got stall=%b want 0", stall_o);
        end
        advance();
    endtask

    task automatic test_reset_midstream();
        drain();
        step(mk(1, 5'd1, 5'd2, 5'd3, 1, 0), 0);
        step(mk(1, 5'd1, 5'd2, 5'd4, 1, 0), 0);
        step(mk(1, 5'd3, 5'd4, 5'd5, 1, 1), 0);
        apply(mk(1, 5'd5, 5'd0, 5'd6, 1, 0), 0);
        n_vec++;
        if (sel_a_o !== 2'b10 || sel_b_o !== 2'b01 || stall_o !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset: got a=%b b=%b stall=%b want 10 01 1", sel_a_o, sel_b_o, stall_o);
        end
        rst_i = 1'b1;
        #1;
        clear_model();
        n_vec++;
        if ({sel_a_o, sel_b_o, stall_o, ex_mem_read_o} !== 6'b0) begin
            n_err++;
            $display("FAIL async_reset: got %b want 000000", {sel_a_o, sel_b_o, stall_o, ex_mem_read_o});
        end
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            apply(nop(), 0);
            n_vec++;
            if (sel_a_o !== 2'b00 || sel_b_o !== 2'b00 || stall_o !== 1'b0) begin
                n_err++;
                $display("FAIL post_reset_empty[%0d]: got a=%b b=%b stall=%b want 00 00 0", k, sel_a_o, sel_b_o, stall_o);
            end
            advance();
        end
    endtask

    task automatic test_random();
        instr_t id;
        bit     fl;
        for (int n = 0; n < 400; n++) begin
            id = mk(($urandom_range(0, 4) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0));
            fl = ($urandom_range(0, 9) == 0);
            apply(id, fl);
            n_vec++;
            if (sel_a_o !== exp_a || sel_b_o !== exp_b || stall_o !== exp_stall || ex_mem_read_o !== exp_emr) begin
                n_err++;
                $display("FAIL rand[%0d]: got a=%b b=%b stall=%b emr=%b want %b %b %b %b",
                         n, sel_a_o, sel_b_o, stall_o, ex_mem_read_o, exp_a, exp_b, exp_stall, exp_emr);
            end
            n_vec++;
            if ((sel_a_o === 2'b01 || sel_b_o === 2'b01) && pipe[1].v && pipe[1].mr) begin
                n_err++;
                $display("FAIL rand_load_mem_fwd[%0d]: got a=%b b=%b with load in MEM", n, sel_a_o, sel_b_o);
            end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_mem_beats_wb();
        test_load_use();
        test_zero_reg();
        test_flush();
        test_reset_midstream();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
